wb_arbiter: RTL
===============

# wb_arbiter

Writeback arbiter between the two backend function-unit pipes (ALU and LSU) and the single completion/writeback port of the RCU. Each pipe pushes completed results through a valid/ready handshake into a private 2-entry FIFO. A round-robin scheduler drains the FIFOs into one registered output port, so the RCU never sees two completions in the same cycle. It sits between `new_fu` outputs and the `rcu` `func_wrb_*` inputs and replaces the dual-port completion path.

## Interface
Parameters:
- `XLEN`, 64: result data width.
- `PHY_REG_ADDR_WIDTH`, 6: physical rd address width.
- `ROB_INDEX_WIDTH`, 4: ROB line index width.
- `EXCEPTION_CODE_WIDTH`, 4: ecause width.
- `FIFO_DEPTH`, 2: entries per source FIFO. Must be a power of 2 and ≥2.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `flush`  in  1  synchronous flush (trap). Drops all buffered results.
- `alu_valid_i` / `lsu_valid_i`  in  1  source has a result this cycle.
- `alu_ready_o` / `lsu_ready_o`  out  1  source FIFO can accept.
- `alu_rob_index_i` / `lsu_rob_index_i`  in  ROB_INDEX_WIDTH  ROB line.
- `alu_rd_valid_i` / `lsu_rd_valid_i`  in  1  result writes a register.
- `alu_rd_addr_i` / `lsu_rd_addr_i`  in  PHY_REG_ADDR_WIDTH  physical rd.
- `alu_data_i` / `lsu_data_i`  in  XLEN  result data.
- `alu_exp_i` / `lsu_exp_i`  in  1  exception raised.
- `alu_ecause_i` / `lsu_ecause_i`  in  EXCEPTION_CODE_WIDTH  exception cause.
- `wb_done_o`  out  1  completion valid to RCU.
- `wb_ready_i`  in  1  RCU accepts the completion.
- `wb_valid_o`  out  1  PRF write enable, equal to `wb_done_o & rd_valid`.
- `wb_rob_index_o`, `wb_rd_addr_o`, `wb_data_o`, `wb_exp_o`, `wb_ecause_o`  out  as inputs  registered payload.
- `wb_src_o`  out  1  source of the current completion: 0 = ALU, 1 = LSU.
- `conflict_cnt_o`  out  16  saturating count of grants made while both FIFOs were non-empty.

## Operation
- **Source push:** a source pushes when `x_valid_i & x_ready_o` at a rising edge. `x_ready_o = (count_x != FIFO_DEPTH)` and depends only on registered state. `x_valid_i` while not ready is ignored; the result is lost and the source must hold it.
- **Output register load:** the output register loads when `(!wb_done_o | wb_ready_i)` and at least one FIFO is non-empty. The loaded FIFO head is popped on the same edge.
- **Grant rule:**
  - Only one FIFO non-empty: grant that FIFO.
  - Both non-empty: grant the source selected by `rr_ptr`.
  - After every grant, `rr_ptr` is set to the source that was not granted.
  - `conflict_cnt_o` increments on every grant made while both FIFOs were non-empty, and saturates at 0xFFFF.
- **Output hold:** while `wb_done_o & !wb_ready_i`, all `wb_*` outputs hold stable.
- **Push into a full FIFO on a pop edge:** push and pop may occur on the same edge. Ready is computed from the pre-edge count, so a full FIFO does not accept a push even on the cycle it is popped.
- **Flush:** on an edge with `flush=1`:
  - Both FIFOs empty, `wb_done_o` clears, `rr_ptr` resets to 0.
  - Pushes sampled on that edge are discarded.
  - `conflict_cnt_o` is not cleared.
- **Reset values:** `wb_done_o=0`, `wb_valid_o=0`, all payload outputs 0, `wb_src_o=0`, `conflict_cnt_o=0`, `rr_ptr=0`, FIFOs empty, `alu_ready_o=lsu_ready_o=1`.
- **Reset mid-operation:** asserting `rstn` low at any time forces all of the reset values above asynchronously, including discarding buffered entries.

## Timing
- **Latency:** push at edge E0 gives `wb_done_o=1` in the cycle after E1 (2 edges minimum), provided the output register is free or drained at E1 and the source is granted.
- **Throughput:** with `wb_ready_i=1`, one completion per cycle sustained. With both sources streaming every cycle, completions alternate ALU, LSU, ALU…, each FIFO fills, and each source's ready drops to a 50% duty cycle.
- **Combinational paths:** none from inputs to outputs. `wb_ready_i` affects only next-state logic.

## Structure
- `params.vh` additions:
  - `WB_ARB_FIFO_DEPTH`.
  - `WB_ENTRY_WIDTH = 1+PHY_REG_ADDR_WIDTH+XLEN+ROB_INDEX_WIDTH+1+EXCEPTION_CODE_WIDTH`.
  - Source encodings `WB_SRC_ALU=0`, `WB_SRC_LSU=1`.
- One sub-module, `wb_fifo`, instantiated twice.
  - Parameterised width and depth.
  - Pointers and count; ports `push`, `pop`, `clear`, `full`, `empty`, `head`.
- Arbitration, output register, `rr_ptr` and counter live in `wb_arbiter`.

## Test plan
- **Single ALU push:** ALU pushes rob=3, rd=12, data=0xDEAD, `wb_ready_i=1` → cycle +2 shows `wb_done_o=1`, `wb_valid_o=1`, `wb_src_o=0`, data 0xDEAD, for exactly one cycle.
- **Simultaneous push:** ALU (rob 1) and LSU (rob 2) push on the same edge after reset → order is rob1 (ALU) then rob2 (LSU) on consecutive cycles; `conflict_cnt_o=1`.
- **Backpressure:** `wb_ready_i=0` for 6 cycles while the ALU pushes 4 results → `alu_ready_o` drops after 3 accepts (2 in FIFO + 1 in the output register), and the payload is held. Release `wb_ready_i` → the 3 accepted results come out in order; the 4th is re-presented and accepted.
- **Flush:** flush with 2 LSU entries buffered and `wb_done_o=1` → next cycle `wb_done_o=0`, both readies 1, and no stale result ever appears.
- **No-register result:** LSU store with `rd_valid=0`, `exp=1`, ecause=6 → `wb_done_o=1`, `wb_valid_o=0`, `wb_exp_o=1`, `wb_ecause_o=6`.
- **Asynchronous reset:** `rstn` low mid-cycle with a full output register → outputs go to 0 immediately; after release, readies are 1 and `conflict_cnt_o=0`.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the writeback arbiter: source encodings, default depth
// and the packed width of one buffered completion.
package wb_arbiter_pkg;

    localparam int WB_ARB_FIFO_DEPTH = 2;

    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_LSU = 1'b1
    } wb_src_e;

    // Entry layout, MSB first: rd_valid, rd_addr, data, rob_index, exp, ecause.
    function automatic int wb_entry_width(input int xlen, input int prd_w,
                                          input int rob_w, input int ecause_w);
        return 1 + prd_w + xlen + rob_w + 1 + ecause_w;
    endfunction

    localparam int WB_ENTRY_WIDTH = wb_entry_width(64, 6, 4, 4);

endpackage

// File: rtl/wb_fifo.sv
// Small per-source completion FIFO. Pushes into a full FIFO and pops from an
// empty one are ignored; clear empties it and wins over a same-edge push.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int WIDTH = WB_ENTRY_WIDTH,
    parameter int DEPTH = WB_ARB_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter: drains the ALU and LSU completion FIFOs into a
// single registered completion port toward the RCU.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int XLEN                 = 64,
    parameter int PHY_REG_ADDR_WIDTH   = 6,
    parameter int ROB_INDEX_WIDTH      = 4,
    parameter int EXCEPTION_CODE_WIDTH = 4,
    parameter int FIFO_DEPTH           = WB_ARB_FIFO_DEPTH
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            flush,

    input  logic                            alu_valid_i,
    output logic                            alu_ready_o,
    input  logic [ROB_INDEX_WIDTH-1:0]      alu_rob_index_i,
    input  logic                            alu_rd_valid_i,
    input  logic [PHY_REG_ADDR_WIDTH-1:0]   alu_rd_addr_i,
    input  logic [XLEN-1:0]                 alu_data_i,
    input  logic                            alu_exp_i,
    input  logic [EXCEPTION_CODE_WIDTH-1:0] alu_ecause_i,

    input  logic                            lsu_valid_i,
    output logic                            lsu_ready_o,
    input  logic [ROB_INDEX_WIDTH-1:0]      lsu_rob_index_i,
    input  logic                            lsu_rd_valid_i,
    input  logic [PHY_REG_ADDR_WIDTH-1:0]   lsu_rd_addr_i,
    input  logic [XLEN-1:0]                 lsu_data_i,
    input  logic                            lsu_exp_i,
    input  logic [EXCEPTION_CODE_WIDTH-1:0] lsu_ecause_i,

    output logic                            wb_done_o,
    input  logic                            wb_ready_i,
    output logic                            wb_valid_o,
    output logic [ROB_INDEX_WIDTH-1:0]      wb_rob_index_o,
    output logic [PHY_REG_ADDR_WIDTH-1:0]   wb_rd_addr_o,
    output logic [XLEN-1:0]                 wb_data_o,
    output logic                            wb_exp_o,
    output logic [EXCEPTION_CODE_WIDTH-1:0] wb_ecause_o,
    output logic                            wb_src_o,
    output logic [15:0]                     conflict_cnt_o
);

    localparam int ENTRY_W  = wb_entry_width(XLEN, PHY_REG_ADDR_WIDTH,
                                             ROB_INDEX_WIDTH, EXCEPTION_CODE_WIDTH);
    localparam int EXP_LSB  = EXCEPTION_CODE_WIDTH;
    localparam int ROB_LSB  = EXP_LSB + 1;
    localparam int DATA_LSB = ROB_LSB + ROB_INDEX_WIDTH;
    localparam int RD_LSB   = DATA_LSB + XLEN;
    localparam int RDV_LSB  = RD_LSB + PHY_REG_ADDR_WIDTH;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [ENTRY_W-1:0] alu_entry;
    logic [ENTRY_W-1:0] lsu_entry;
    logic [ENTRY_W-1:0] alu_head;
    logic [ENTRY_W-1:0] lsu_head;
    logic               alu_full;
    logic               alu_empty;
    logic               lsu_full;
    logic               lsu_empty;

    logic               both_p0;
    logic               any_p0;
    logic               load_p0;
    wb_src_e            grant_p0;
    logic [ENTRY_W-1:0] head_p0;
    logic               pop_alu_p0;
    logic               pop_lsu_p0;

    logic               vld_p1;
    wb_src_e            src_p1;
    logic [ENTRY_W-1:0] entry_p1;
    wb_src_e            rr_ptr;
    logic [15:0]        conflict_cnt;

    assign alu_entry = {alu_rd_valid_i, alu_rd_addr_i, alu_data_i,
                        alu_rob_index_i, alu_exp_i, alu_ecause_i};
    assign lsu_entry = {lsu_rd_valid_i, lsu_rd_addr_i, lsu_data_i,
                        lsu_rob_index_i, lsu_exp_i, lsu_ecause_i};

    // Ready comes from the pre-edge count only, so a full FIFO refuses a push
    // even on the edge it is popped.
    assign alu_ready_o = ~alu_full;
    assign lsu_ready_o = ~lsu_full;

    wb_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_alu_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (alu_valid_i),
        .pop   (pop_alu_p0),
        .clear (flush),
        .din   (alu_entry),
        .full  (alu_full),
        .empty (alu_empty),
        .head  (alu_head)
    );

    wb_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_lsu_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (lsu_valid_i),
        .pop   (pop_lsu_p0),
        .clear (flush),
        .din   (lsu_entry),
        .full  (lsu_full),
        .empty (lsu_empty),
        .head  (lsu_head)
    );

    // Stage p0: grant selection between the FIFO heads.
    always_comb begin
        both_p0  = ~alu_empty & ~lsu_empty;
        any_p0   = ~alu_empty | ~lsu_empty;
        grant_p0 = WB_SRC_ALU;
        if (both_p0)
            grant_p0 = rr_ptr;
        else if (alu_empty)
            grant_p0 = WB_SRC_LSU;
        load_p0    = any_p0 & (~vld_p1 | wb_ready_i) & ~flush;
        head_p0    = (grant_p0 == WB_SRC_LSU) ? lsu_head : alu_head;
        pop_alu_p0 = load_p0 & (grant_p0 == WB_SRC_ALU);
        pop_lsu_p0 = load_p0 & (grant_p0 == WB_SRC_LSU);
    end

    // Stage p1: registered completion port, round-robin pointer and counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_p1       <= 1'b0;
            src_p1       <= WB_SRC_ALU;
            entry_p1     <= '0;
            rr_ptr       <= WB_SRC_ALU;
            conflict_cnt <= '0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
            rr_ptr <= WB_SRC_ALU;
        end else if (load_p0) begin
            vld_p1   <= 1'b1;
            src_p1   <= grant_p0;
            entry_p1 <= head_p0;
            rr_ptr   <= (grant_p0 == WB_SRC_ALU) ? WB_SRC_LSU : WB_SRC_ALU;
            if (both_p0)
                conflict_cnt <= sat_inc16(conflict_cnt);
        end else if (wb_ready_i) begin
            vld_p1 <= 1'b0;
        end
    end

    assign wb_done_o      = vld_p1;
    assign wb_valid_o     = vld_p1 & entry_p1[RDV_LSB];
    assign wb_rd_addr_o   = entry_p1[RD_LSB +: PHY_REG_ADDR_WIDTH];
    assign wb_data_o      = entry_p1[DATA_LSB +: XLEN];
    assign wb_rob_index_o = entry_p1[ROB_LSB +: ROB_INDEX_WIDTH];
    assign wb_exp_o       = entry_p1[EXP_LSB];
    assign wb_ecause_o    = entry_p1[EXCEPTION_CODE_WIDTH-1:0];
    assign wb_src_o       = src_p1;
    assign conflict_cnt_o = conflict_cnt;

endmodule
